// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared widths, reset divisor and channel limits for the tick generator
package tick_gen_pkg;
  localparam int unsigned TG_CNT_W = 20;
  localparam int unsigned TG_DEFAULT_DIV = 262144;
  localparam int MAX_CH = 16;
  localparam int CH_W = $clog2(MAX_CH);
  typedef logic [TG_CNT_W-1:0] cnt_t;
endpackage

// File: rtl/tick_gen_chan.sv
// tick_gen_chan: one clock-enable channel with shadowed divisor; sq flop only with TICK_GEN_SQUARE_EN
module tick_gen_chan import tick_gen_pkg::*; #(
  parameter int CNT_W = TG_CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(TG_DEFAULT_DIV)
) (
  input  logic             hsosc_clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic             restart_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             tick_o,
  output logic             sq_o,
  output logic             div_pend_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, shadow_q, shadow_d;
  logic pend_q, pend_d, tick_q, tick_d, wrap, commit;
  // >= rather than == so a divisor shrunk below the held count still wraps at once
  always_comb begin
    wrap = en_i && div_q != '0 && cnt_q >= div_q - CNT_W'(1);
    commit = pend_q && (wrap || div_q == '0 || !en_i);
    tick_d = wrap && !restart_i;
    cnt_d = restart_i ? '0 : !en_i ? cnt_q : (wrap || div_q == '0) ? '0 : cnt_q + CNT_W'(1);
    div_d = (restart_i && we_i) ? div_i : ((restart_i || commit) && pend_q) ? shadow_q : div_q;
    shadow_d = we_i ? div_i : shadow_q;
    pend_d = restart_i ? 1'b0 : we_i ? 1'b1 : commit ? 1'b0 : pend_q;
  end
  always_ff @(posedge hsosc_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
      div_q <= DEFAULT_DIV;
      shadow_q <= '0;
      pend_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      shadow_q <= shadow_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
    end
  end
  assign tick_o = tick_q;
  assign div_pend_o = pend_q;
`ifdef TICK_GEN_SQUARE_EN
  logic sq_q;
  always_ff @(posedge hsosc_clk_i or negedge reset_i) begin
    if (!reset_i) sq_q <= 1'b0;
    else sq_q <= sq_q ^ tick_d;
  end
  assign sq_o = sq_q;
`else
  assign sq_o = 1'b0;
`endif
endmodule

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: N_CH independent clock-enable channels; square outputs only with TICK_GEN_SQUARE_EN
module tick_gen_multi import tick_gen_pkg::*; #(
  parameter int N_CH = 4,
  parameter int CNT_W = TG_CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(TG_DEFAULT_DIV)
) (
  input  logic             hsosc_clk_i,
  input  logic             reset_i,
  input  logic [N_CH-1:0]  en_i,
  input  logic             cfg_we_i,
  input  logic [CH_W-1:0]  cfg_ch_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  input  logic             cfg_restart_i,
  output logic [N_CH-1:0]  tick_o,
  output logic [N_CH-1:0]  sq_o,
  output logic [N_CH-1:0]  div_pend_o
);
  // out-of-range channel indices match no channel and are dropped
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    tick_gen_chan #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_chan (
      .hsosc_clk_i(hsosc_clk_i),
      .reset_i(reset_i),
      .en_i(en_i[i]),
      .we_i(cfg_we_i && cfg_ch_i == CH_W'(i)),
      .restart_i(cfg_restart_i && cfg_ch_i == CH_W'(i)),
      .div_i(cfg_div_i),
      .tick_o(tick_o[i]),
      .sq_o(sq_o[i]),
      .div_pend_o(div_pend_o[i])
    );
  end
endmodule
